// File: rtl/if_stage_if.sv
// ============================================================================
// Module      : if_stage_if
// Description : IF stage bundle: control/fetch inputs and IF/ID register outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface if_stage_if;
   logic        stall;
   logic        intReq;
   logic        eretFlush;
   logic [31:0] NPC;
   logic        IDIsBJ;
   logic [31:0] instrIn;
   logic [31:0] PC;
   logic [31:0] IDInstr;
   logic [31:0] IDPC;
   logic [4:0]  IDExcCode;
   logic        IDBD;
   logic [31:0] fetchCount;

   // Pipeline/memory side drives the controls and consumes the IF/ID register.
   modport master (
      output stall, intReq, eretFlush, NPC, IDIsBJ, instrIn,
      input  PC, IDInstr, IDPC, IDExcCode, IDBD, fetchCount
   );

   // The fetch stage itself.
   modport slave (
      input  stall, intReq, eretFlush, NPC, IDIsBJ, instrIn,
      output PC, IDInstr, IDPC, IDExcCode, IDBD, fetchCount
   );
endinterface

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// Module      : if_stage
// Description : P7 MIPS instruction-fetch stage: fetch PC and IF/ID register.
//               Fetch address-error detection enabled by IF_ADDR_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] IM_BASE  = 32'h0000_3000,
   parameter logic [31:0] IM_TOP   = 32'h0000_6FFF,
   parameter logic [4:0]  EXC_ADEL = 5'd4
) (
   input  wire        clk,
   input  wire        reset,
   if_stage_if.slave  bus
);

   logic [31:0] r_pc;
   logic [31:0] r_id_instr;
   logic [31:0] r_id_pc;
   logic [4:0]  r_id_exc;
   logic        r_id_bd;
   logic [31:0] r_fetch_cnt;

   logic        w_flush;
   logic        w_addr_err;

   assign w_flush = bus.intReq | bus.eretFlush;

`ifdef IF_ADDR_CHECK_EN
   assign w_addr_err = (r_pc[1:0] != 2'b00) || (r_pc < IM_BASE) || (r_pc > IM_TOP);
`else
   logic w_unused_cfg;
   assign w_addr_err   = 1'b0;
   assign w_unused_cfg = ^{IM_BASE, IM_TOP};
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc        <= RESET_PC;
         r_id_instr  <= 32'd0;
         r_id_pc     <= RESET_PC;
         r_id_exc    <= 5'd0;
         r_id_bd     <= 1'b0;
         r_fetch_cnt <= 32'd0;
      end else if (w_flush) begin
         // Bubble carries the redirect target so a later EPC is still meaningful.
         r_pc       <= bus.NPC;
         r_id_instr <= 32'd0;
         r_id_pc    <= bus.NPC;
         r_id_exc   <= 5'd0;
         r_id_bd    <= 1'b0;
      end else if (!bus.stall) begin
         r_pc        <= bus.NPC;
         r_id_instr  <= w_addr_err ? 32'd0 : bus.instrIn;
         r_id_pc     <= r_pc;
         r_id_exc    <= w_addr_err ? EXC_ADEL : 5'd0;
         r_id_bd     <= bus.IDIsBJ;
         r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
   end

   assign bus.PC         = r_pc;
   assign bus.IDInstr    = r_id_instr;
   assign bus.IDPC       = r_id_pc;
   assign bus.IDExcCode  = r_id_exc;
   assign bus.IDBD       = r_id_bd;
   assign bus.fetchCount = r_fetch_cnt;

endmodule

`default_nettype wire

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the P7 MIPS pipeline.
- Holds the architectural fetch PC, drives it to instruction memory and to the next-PC logic, and loads the next-PC result each cycle.
- Owns the IF/ID pipeline register, which carries instruction, PC, fetch exception code and branch-delay flag into ID.
- Handles stall, interrupt/eret flush and fetch address-error detection.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_TOP, 32'h0000_6FFF, highest legal fetch address (inclusive).
- EXC_ADEL, 5'd4, ExcCode written for a fetch address error.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hazard-unit stall; hold PC and IF/ID.
- intReq  input  1  CP0 interrupt/exception request; flush IF/ID and redirect.
- eretFlush  input  1  eret committing in MEM; flush IF/ID and redirect.
- NPC  input  32  next fetch address from the next-PC block (already resolves eret/intReq/branch/jump priority).
- IDIsBJ  input  1  instruction currently in ID is a branch or jump; the word now in IF is its delay slot.
- instrIn  input  32  instruction word read from IM at PC.
- PC  output  32  current fetch address, to IM and next-PC block.
- IDInstr  output  32  IF/ID instruction.
- IDPC  output  32  IF/ID PC.
- IDExcCode  output  5  IF/ID exception code, 0 means none.
- IDBD  output  1  IF/ID branch-delay-slot flag.
- fetchCount  output  32  number of instructions accepted into ID since reset.

Behaviour:
- Reset (async, any time, including mid-stall or mid-flush):
  - PC=RESET_PC.
  - IDInstr=0, IDPC=RESET_PC, IDExcCode=0, IDBD=0, fetchCount=0.
- Priority at each rising edge: reset > (intReq | eretFlush) > stall > normal.
- Flush (intReq or eretFlush high; either or both):
  - PC<=NPC. Stall is ignored.
  - IF/ID becomes a bubble: IDInstr<=0, IDExcCode<=0, IDBD<=0, IDPC<=NPC, so a bubble's PC is the redirect target and EPC stays meaningful.
  - fetchCount unchanged.
- Stall (no flush): PC, all ID* outputs and fetchCount hold their values.
- Normal:
  - PC<=NPC.
  - IDInstr<=instrIn, IDPC<=PC, IDBD<=IDIsBJ.
  - IDExcCode<=EXC_ADEL on address error, else 0.
  - fetchCount<=fetchCount+1, wrapping modulo 2^32.
- Address error: PC[1:0]!=0, or PC<IM_BASE, or PC>IM_TOP.
  - On error, IDInstr<=0 (nop) and instrIn is discarded.
  - IDPC still gets the faulting PC so CP0 reports it as EPC/BadVAddr.
- Latency: instruction at PC appears on ID* outputs one cycle after the edge at which PC is valid and not stalled.
- All outputs are registered. There is no combinational path from any input to any output.
- Consecutive stall cycles are unbounded. The stall→flush transition flushes on the first edge intReq/eretFlush is sampled high.

Optional Feature:
- Macro: IF_ADDR_CHECK_EN.
- Defined: address-error detection as above.
- Not defined: no range or alignment checking. IDExcCode is always 0 and IDInstr is always instrIn on normal cycles, which saves area for configurations without exception support.
- Flush, stall and fetchCount behaviour are identical in both builds.

Test Plan:
- Reset then 3 free-running cycles with NPC=PC+4 and instrIn=32'h2408_0001 → PC sequence 0x3000, 0x3004, 0x3008, 0x300C; IDPC lags PC by one cycle; fetchCount=3.
- stall=1 for 2 cycles at PC=0x3008 → PC stays 0x3008 and ID* hold for both cycles; release → resumes, and fetchCount increments only on unstalled edges.
- IDIsBJ=1 on a normal edge with PC=0x3010 → IDBD=1, IDPC=0x3010; next edge with IDIsBJ=0 → IDBD=0.
- intReq=1 together with stall=1, NPC=0x4180 → PC=0x4180, IDInstr=0, IDPC=0x4180, IDBD=0, fetchCount unchanged.
- NPC=0x3002, then a normal edge (IF_ADDR_CHECK_EN defined) → IDExcCode=4, IDInstr=0, IDPC=0x3002. NPC=0x7000 behaves the same way. Not defined → IDExcCode=0, IDInstr=instrIn.
- Assert reset asynchronously mid-cycle during stall with PC=0x3020 → PC=0x3000 and all ID*/fetchCount cleared immediately, without waiting for a clock edge.
